// File: rtl/lcd_byte_sequencer.sv
// lcd_byte_sequencer: 4-bit LCD power-on init, config bytes and host byte writes as nibble strobes; define LCD_AUTO_INIT_EN to start init right after reset
module lcd_byte_sequencer #(
  parameter int unsigned T_EN     = 12,
  parameter int unsigned T_NIB    = 50,
  parameter int unsigned T_40US   = 2000,
  parameter int unsigned T_100US  = 5000,
  parameter int unsigned T_1640US = 82000,
  parameter int unsigned T_4MS    = 205000,
  parameter int unsigned T_15MS   = 750000,
  parameter int unsigned CNT_W    = 20
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       startInit,
  input  logic       wrReq,
  input  logic       wrRS,
  input  logic [7:0] wrData,
  output logic       wrReady,
  output logic       busy,
  output logic       initDone,
  output logic       lcdE,
  output logic       lcdRS,
  output logic       lcdRW,
  output logic [3:0] lcdData
);
  typedef enum logic [3:0] {
    UNINIT, PWR_WAIT, INIT_SETUP, INIT_PULSE, INIT_WAIT, READY,
    HI_SETUP, HI_PULSE, HI_GAP, LO_SETUP, LO_PULSE, LO_WAIT
  } state_t;
  state_t state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [2:0] idx_d, idx_q;
  logic [7:0] byte_d, byte_q;
  logic rs_d, rs_q, cfg_d, cfg_q, done_d, done_q;
  logic e_d, e_q, lrs_d, lrs_q, rdy_d, rdy_q, busy_d, busy_q;
  logic [3:0] nib_d, nib_q;
  logic go, zero;
  function automatic logic [CNT_W-1:0] ld(input int unsigned t);
    return CNT_W'(t - 1);
  endfunction
  function automatic logic [7:0] cfg_byte(input logic [2:0] i);
    return i == 3'd0 ? 8'h28 : i == 3'd1 ? 8'h06 : i == 3'd2 ? 8'h0C : 8'h01;
  endfunction
`ifdef LCD_AUTO_INIT_EN
  logic unused_start_init;
  assign unused_start_init = startInit;
  assign go = 1'b1;
`else
  assign go = startInit;
`endif
  assign zero = cnt_q == '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - CNT_W'(1);
    idx_d   = idx_q;
    byte_d  = byte_q;
    rs_d    = rs_q;
    cfg_d   = cfg_q;
    done_d  = done_q;
    case (state_q)
      UNINIT: begin
        cnt_d = '0;
        if (go) begin
          state_d = PWR_WAIT;
          cnt_d   = ld(T_15MS);
        end
      end
      PWR_WAIT: if (zero) begin
        state_d = INIT_SETUP;
        idx_d   = '0;
      end
      INIT_SETUP: begin
        state_d = INIT_PULSE;
        cnt_d   = ld(T_EN);
      end
      INIT_PULSE: if (zero) begin
        state_d = INIT_WAIT;
        cnt_d   = ld(idx_q == 3'd0 ? T_4MS : idx_q == 3'd1 ? T_100US : T_40US);
      end
      INIT_WAIT: if (zero) begin
        state_d = idx_q == 3'd3 ? HI_SETUP : INIT_SETUP;
        idx_d   = idx_q == 3'd3 ? 3'd0 : idx_q + 3'd1;
        byte_d  = idx_q == 3'd3 ? cfg_byte(3'd0) : byte_q;
        rs_d    = idx_q == 3'd3 ? 1'b0 : rs_q;
        cfg_d   = idx_q == 3'd3 ? 1'b1 : cfg_q;
      end
      READY: begin
        cnt_d = '0;
        if (wrReq) begin
          state_d = HI_SETUP;
          byte_d  = wrData;
          rs_d    = wrRS;
        end
      end
      HI_SETUP: begin
        state_d = HI_PULSE;
        cnt_d   = ld(T_EN);
      end
      HI_PULSE: if (zero) begin
        state_d = HI_GAP;
        cnt_d   = ld(T_NIB);
      end
      HI_GAP: if (zero) state_d = LO_SETUP;
      LO_SETUP: begin
        state_d = LO_PULSE;
        cnt_d   = ld(T_EN);
      end
      LO_PULSE: if (zero) begin
        state_d = LO_WAIT;
        cnt_d   = ld((!rs_q && byte_q[7:2] == 6'd0) ? T_1640US : T_40US);
      end
      LO_WAIT: if (zero) begin
        if (cfg_q && idx_q != 3'd3) begin
          state_d = HI_SETUP;
          idx_d   = idx_q + 3'd1;
          byte_d  = cfg_byte(idx_q + 3'd1);
        end else begin
          state_d = READY;
          cfg_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = UNINIT;
        cnt_d   = '0;
      end
    endcase
    e_d    = state_d inside {INIT_PULSE, HI_PULSE, LO_PULSE};
    lrs_d  = state_d inside {HI_SETUP, HI_PULSE, HI_GAP, LO_SETUP, LO_PULSE, LO_WAIT} ? rs_d : 1'b0;
    nib_d  = state_d inside {INIT_SETUP, INIT_PULSE, INIT_WAIT} ? (idx_d == 3'd3 ? 4'h2 : 4'h3) :
             state_d inside {HI_SETUP, HI_PULSE, HI_GAP} ? byte_d[7:4] :
             state_d inside {LO_SETUP, LO_PULSE, LO_WAIT} ? byte_d[3:0] : 4'h0;
    rdy_d  = state_d == READY;
    busy_d = !(state_d inside {UNINIT, READY});
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= UNINIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      byte_q  <= '0;
      rs_q    <= 1'b0;
      cfg_q   <= 1'b0;
      done_q  <= 1'b0;
      e_q     <= 1'b0;
      lrs_q   <= 1'b0;
      nib_q   <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      byte_q  <= byte_d;
      rs_q    <= rs_d;
      cfg_q   <= cfg_d;
      done_q  <= done_d;
      e_q     <= e_d;
      lrs_q   <= lrs_d;
      nib_q   <= nib_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end
  assign wrReady  = rdy_q;
  assign busy     = busy_q;
  assign initDone = done_q;
  assign lcdE     = e_q;
  assign lcdRS    = lrs_q;
  assign lcdRW    = 1'b0;
  assign lcdData  = nib_q;
endmodule

// File: tb/tb_lcd_byte_sequencer.sv
// tb_lcd_byte_sequencer: randomized scoreboard bench for lcd_byte_sequencer
module tb_lcd_byte_sequencer;
  localparam int T_EN = 3, T_NIB = 2, T_40US = 4, T_100US = 5, T_1640US = 12, T_4MS = 10, T_15MS = 30;
  logic clk = 1'b0, rst = 1'b1, start_init = 1'b0, wr_req = 1'b0, wr_rs = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic wr_ready, busy, init_done, lcd_e, lcd_rs, lcd_rw;
  logic [3:0] lcd_data;
  int total = 0, bad = 0, cyc = 0, start_cyc = 0;
  typedef struct {logic rs; logic [3:0] d; int w; bit chain; bit first;} pulse_t;
  pulse_t exp_q[$];
  lcd_byte_sequencer #(
    .T_EN(T_EN), .T_NIB(T_NIB), .T_40US(T_40US), .T_100US(T_100US),
    .T_1640US(T_1640US), .T_4MS(T_4MS), .T_15MS(T_15MS), .CNT_W(20)
  ) dut (
    .CLK(clk), .RESET(rst), .startInit(start_init), .wrReq(wr_req), .wrRS(wr_rs),
    .wrData(wr_data), .wrReady(wr_ready), .busy(busy), .initDone(init_done),
    .lcdE(lcd_e), .lcdRS(lcd_rs), .lcdRW(lcd_rw), .lcdData(lcd_data)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask
  function automatic int wpost(input logic rs, input logic [7:0] b);
    return (!rs && b < 8'h04) ? T_1640US : T_40US;
  endfunction
  function automatic int blen(input logic rs, input logic [7:0] b);
    return 2 + 2 * T_EN + T_NIB + wpost(rs, b);
  endfunction
  task automatic push_byte(input logic rs, input logic [7:0] b, input bit chain);
    exp_q.push_back('{rs, b[7:4], T_NIB, chain, 1'b0});
    exp_q.push_back('{rs, b[3:0], wpost(rs, b), 1'b1, 1'b0});
  endtask
  int init_waits[4] = '{T_4MS, T_100US, T_40US, T_40US};
  logic [3:0] init_nibs[4] = '{4'h3, 4'h3, 4'h3, 4'h2};
  logic [7:0] cfg_bytes[4] = '{8'h28, 8'h06, 8'h0C, 8'h01};
  function automatic int init_len();
    int s = 1 + T_15MS;
    for (int i = 0; i < 4; i++) s += 1 + T_EN + init_waits[i] + blen(1'b0, cfg_bytes[i]);
    return s;
  endfunction
  // monitor: pops one expected nibble per E rising edge and checks width, hold and gaps
  logic prev_e = 1'b0;
  bit have_prev = 1'b0;
  int hi_cnt = 0, low_cnt = 0, prev_w = 0;
  pulse_t cur;
  always @(negedge clk) begin
    if (rst) begin
      prev_e = 1'b0;
      have_prev = 1'b0;
      hi_cnt = 0;
      low_cnt = 0;
    end else begin
      if (lcd_e && !prev_e) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse actual=%0h required=no_pulse", lcd_data);
        end else begin
          cur = exp_q.pop_front();
          check("nibble_data", 32'(lcd_data), 32'(cur.d));
          check("nibble_rs", 32'(lcd_rs), 32'(cur.rs));
          check("lcd_rw", 32'(lcd_rw), 0);
          if (cur.chain && have_prev) check("e_low_gap", low_cnt, prev_w + 1);
          if (cur.first) check("first_rise", cyc - start_cyc, T_15MS + 1);
        end
        hi_cnt = 1;
      end else if (lcd_e) begin
        hi_cnt++;
      end else if (prev_e) begin
        check("pulse_width", hi_cnt, T_EN);
        check("hold_data", {lcd_rs, lcd_data}, {cur.rs, cur.d});
        prev_w = cur.w;
        have_prev = 1'b1;
        low_cnt = 1;
      end else begin
        low_cnt++;
      end
      prev_e = lcd_e;
    end
  end
  task automatic run_init();
    int n;
    for (int i = 0; i < 4; i++) exp_q.push_back('{1'b0, init_nibs[i], init_waits[i], i != 0, i == 0});
    for (int i = 0; i < 4; i++) push_byte(1'b0, cfg_bytes[i], 1'b1);
    start_init = 1'b1;
    @(posedge clk);
    #1 start_init = 1'b0;
    start_cyc = cyc;
    n = 1;
    while (!init_done && n < 2000) begin
      @(posedge clk);
      #1 n++;
    end
    check("init_len", n, init_len());
    check("ready_with_done", 32'(wr_ready), 1);
    check("busy_after_init", 32'(busy), 0);
    check("init_queue_empty", exp_q.size(), 0);
  endtask
  task automatic write_byte(input logic rs, input logic [7:0] b, input bit hold);
    int n = 0;
    while (!wr_ready && n < 1000) begin
      @(posedge clk);
      #1 n++;
    end
    check("ready_before_write", 32'(wr_ready), 1);
    wr_req = 1'b1;
    wr_rs = rs;
    wr_data = b;
    push_byte(rs, b, 1'b0);
    @(posedge clk);
    #1;
    if (!hold) wr_req = 1'b0;
    check("busy_after_accept", {wr_ready, busy}, 2'b01);
    n = 0;
    while (!wr_ready && n < 1000) begin
      n++;
      start_init = n == 2;
      if (n == 3) begin
        wr_data = 8'($urandom);
        wr_rs = 1'($urandom);
      end
      @(posedge clk);
      #1;
    end
    start_init = 1'b0;
    check("busy_len", n, blen(rs, b));
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
  initial begin
    logic [7:0] b;
    logic rs;
    bit hold;
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {wr_ready, busy, init_done, lcd_e, lcd_rs, lcd_rw, lcd_data}, 0);
    rst = 1'b0;
    repeat (50) begin
      @(posedge clk);
      #1 check("idle_outputs", {wr_ready, busy, init_done, lcd_e, lcd_rs, lcd_rw, lcd_data}, 0);
    end
    run_init();
    write_byte(1'b1, 8'h41, 1'b0);
    write_byte(1'b0, 8'h01, 1'b0);
    for (int i = 0; i < 14; i++) begin
      rs = 1'($urandom);
      b = ($urandom % 2) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      hold = (i != 13) && ($urandom % 2);
      write_byte(rs, b, hold);
      if (!hold) repeat ($urandom_range(0, 3)) @(posedge clk);
      #0;
    end
    start_init = 1'b1;
    @(posedge clk);
    #1 start_init = 1'b0;
    repeat (5) begin
      check("no_reinit", {wr_ready, busy, init_done}, 3'b101);
      @(posedge clk);
      #1;
    end
    wr_req = 1'b1;
    wr_rs = 1'b1;
    wr_data = 8'($urandom);
    push_byte(1'b1, wr_data, 1'b0);
    @(posedge clk);
    #1 wr_req = 1'b0;
    repeat (8) @(posedge clk);
    #1 check("lo_pulse_reached", 32'(lcd_e), 1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 check("reset_mid_pulse", {wr_ready, busy, init_done, lcd_e}, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1 check("uninit_after_reset", {wr_ready, busy, init_done, lcd_e}, 0);
    end
    run_init();
    write_byte(1'b0, 8'h02, 1'b0);
    write_byte(1'b1, 8'h5A, 1'b0);
    repeat (5) @(posedge clk);
    #1 check("final_queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
